// File: rtl/wave_sample_streamer.sv
// Burst sample generator: steps a time argument through an external waveform compute and
// queues the upper W result bits in a FIFO drained by a host read strobe.
module wave_sample_streamer #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned W     = 16
) (
  input  logic                     ti_clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [15:0]              n_samples,
  input  logic [15:0]              t_step,
  output logic [15:0]              t_out,
  input  logic [31:0]              result_in,
  input  logic                     rd_req,
  output logic [W-1:0]             rd_data,
  output logic                     rd_valid,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] FullLevel = LW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q;
  logic [15:0]     t_out_q;
  logic [15:0]     remaining_q;
  logic [15:0]     step_q;
  logic            busy_q;
  logic            done_q;

  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [LW-1:0]   level_q;
  logic [W-1:0]    rd_data_q;
  logic            rd_valid_q;
  logic            underflow_q;
  logic [W-1:0]    mem_q [DEPTH];

  logic            full;
  logic            empty;
  logic            wr_en;
  logic            rd_en;
  logic            unused_result;

  // Fullness/emptiness use the occupancy at the start of the cycle, before any same-cycle pop.
  assign full  = (level_q == FullLevel);
  assign empty = (level_q == '0);
  assign wr_en = (state_q == StRun) && !full;
  assign rd_en = rd_req && !empty;

  assign unused_result = ^result_in;

  // Sequencer: burst control and time argument generation.
  always_ff @(posedge ti_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      t_out_q     <= '0;
      remaining_q <= '0;
      step_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            remaining_q <= n_samples;
            step_q      <= t_step;
            t_out_q     <= '0;
            if (n_samples == '0) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= StRun;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end
          end
        end
        StRun: begin
          if (!full) begin
            t_out_q     <= t_out_q + step_q;
            remaining_q <= remaining_q - 16'd1;
            if (remaining_q == 16'd1) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // FIFO storage carries no reset; validity is tracked by the pointers and level.
  always_ff @(posedge ti_clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= result_in[31 -: W];
    end
  end

  always_ff @(posedge ti_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (rd_en) begin
        rd_ptr_q  <= rd_ptr_q + AW'(1);
        rd_data_q <= mem_q[rd_ptr_q];
      end
      if (rd_req && empty) begin
        underflow_q <= 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  assign t_out     = t_out_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign level     = level_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_wave_sample_streamer.sv
// Directed bench for wave_sample_streamer: a cycle table for a basic burst plus hand-written
// sequences for stall, underflow, empty burst, time wrap and mid-burst reset.
module tb_wave_sample_streamer;

  localparam int DEPTH = 16;
  localparam int W     = 16;

  logic        ti_clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] n_samples;
  logic [15:0] t_step;
  logic [15:0] t_out;
  logic [31:0] result_in;
  logic        rd_req;
  logic [W-1:0] rd_data;
  logic        rd_valid;
  logic        busy;
  logic        done;
  logic [4:0]  level;
  logic        underflow;

  int n_checks = 0;
  int n_fail   = 0;

  wave_sample_streamer #(
    .DEPTH(DEPTH),
    .W    (W)
  ) dut (
    .ti_clk   (ti_clk),
    .rst_n    (rst_n),
    .start    (start),
    .n_samples(n_samples),
    .t_step   (t_step),
    .t_out    (t_out),
    .result_in(result_in),
    .rd_req   (rd_req),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .busy     (busy),
    .done     (done),
    .level    (level),
    .underflow(underflow)
  );

  always #5 ti_clk = ~ti_clk;

  // External compute: the sample equals the time argument.
  assign result_in = {t_out, 16'h0000};

  typedef struct {
    logic        start;
    logic [15:0] n;
    logic [15:0] step;
    logic        rd;
    logic        busy;
    logic        done;
    logic        rv;
    logic [4:0]  lvl;
    logic [15:0] data;
    logic [15:0] tout;
    logic        uf;
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ti_clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    start     = 1'b0;
    rd_req    = 1'b0;
    n_samples = '0;
    t_step    = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic check_reset(input string tag);
    check({tag, " t_out"},     64'(t_out),     64'h0);
    check({tag, " level"},     64'(level),     64'h0);
    check({tag, " rd_data"},   64'(rd_data),   64'h0);
    check({tag, " rd_valid"},  64'(rd_valid),  64'h0);
    check({tag, " busy"},      64'(busy),      64'h0);
    check({tag, " done"},      64'(done),      64'h0);
    check({tag, " underflow"}, 64'(underflow), 64'h0);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    rd_req    = 1'b0;
    n_samples = '0;
    t_step    = '0;

    //        start  n      step   rd    busy  done  rv    lvl   data    tout    uf
    tbl[0]  = '{1'b1, 16'd4, 16'd3, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 16'd0, 16'd0,  1'b0};
    tbl[1]  = '{1'b0, 16'd4, 16'd3, 1'b0, 1'b1, 1'b0, 1'b0, 5'd1, 16'd0, 16'd3,  1'b0};
    tbl[2]  = '{1'b0, 16'd4, 16'd3, 1'b0, 1'b1, 1'b0, 1'b0, 5'd2, 16'd0, 16'd6,  1'b0};
    tbl[3]  = '{1'b0, 16'd4, 16'd3, 1'b0, 1'b1, 1'b0, 1'b0, 5'd3, 16'd0, 16'd9,  1'b0};
    tbl[4]  = '{1'b0, 16'd4, 16'd3, 1'b0, 1'b0, 1'b1, 1'b0, 5'd4, 16'd0, 16'd12, 1'b0};
    tbl[5]  = '{1'b0, 16'd4, 16'd3, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 16'd0, 16'd12, 1'b0};
    tbl[6]  = '{1'b0, 16'd4, 16'd3, 1'b1, 1'b0, 1'b1, 1'b1, 5'd2, 16'd3, 16'd12, 1'b0};
    tbl[7]  = '{1'b0, 16'd4, 16'd3, 1'b0, 1'b0, 1'b1, 1'b0, 5'd2, 16'd3, 16'd12, 1'b0};
    tbl[8]  = '{1'b0, 16'd4, 16'd3, 1'b1, 1'b0, 1'b1, 1'b1, 5'd1, 16'd6, 16'd12, 1'b0};
    tbl[9]  = '{1'b0, 16'd4, 16'd3, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 16'd9, 16'd12, 1'b0};
    tbl[10] = '{1'b0, 16'd4, 16'd3, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 16'd9, 16'd12, 1'b1};

    // Reset values
    do_reset();
    check_reset("reset");

    // Basic 4-sample burst, then drain past empty
    for (int i = 0; i < 11; i++) begin
      start     = tbl[i].start;
      n_samples = tbl[i].n;
      t_step    = tbl[i].step;
      rd_req    = tbl[i].rd;
      tick();
      check($sformatf("burst4 vec%0d {busy,done,rv,lvl,data,tout,uf}", i),
            64'({busy, done, rd_valid, level, rd_data, t_out, underflow}),
            64'({tbl[i].busy, tbl[i].done, tbl[i].rv, tbl[i].lvl, tbl[i].data, tbl[i].tout,
                 tbl[i].uf}));
    end
    rd_req = 1'b0;

    // Full-FIFO stall with n_samples=20
    do_reset();
    start = 1'b1; n_samples = 16'd20; t_step = 16'd3;
    tick();
    start = 1'b0;
    repeat (16) tick();
    check("stall level", 64'(level), 64'd16);
    check("stall busy",  64'(busy),  64'd1);
    check("stall t_out", 64'(t_out), 64'd48);
    repeat (3) tick();
    check("stall hold level", 64'(level), 64'd16);
    check("stall hold t_out", 64'(t_out), 64'd48);
    rd_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("stall read%0d data", i), 64'(rd_data), 64'(3 * i));
      check($sformatf("stall read%0d valid", i), 64'(rd_valid), 64'd1);
      check($sformatf("stall read%0d done", i), 64'(done), 64'(i == 4));
      if (i == 0) begin
        check("full judged before read: level", 64'(level), 64'd15);
        check("full judged before read: t_out", 64'(t_out), 64'd48);
      end
    end
    rd_req = 1'b0;
    check("stall end level", 64'(level), 64'd15);
    check("stall end busy",  64'(busy),  64'd0);

    // Underflow after reset is sticky across a good read
    do_reset();
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    check("uflow valid", 64'(rd_valid), 64'd0);
    check("uflow flag",  64'(underflow), 64'd1);
    check("uflow level", 64'(level), 64'd0);
    start = 1'b1; n_samples = 16'd1; t_step = 16'd5;
    tick();
    start = 1'b0;
    tick();
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    check("uflow good read valid", 64'(rd_valid), 64'd1);
    check("uflow sticky",          64'(underflow), 64'd1);
    tick();
    check("rd_valid one-cycle", 64'(rd_valid), 64'd0);

    // Zero-length burst
    do_reset();
    start = 1'b1; n_samples = 16'd0; t_step = 16'd9;
    tick();
    start = 1'b0;
    check("n0 done",  64'(done),  64'd1);
    check("n0 busy",  64'(busy),  64'd0);
    check("n0 level", 64'(level), 64'd0);
    repeat (2) tick();
    check("n0 level hold", 64'(level), 64'd0);
    check("n0 t_out",      64'(t_out), 64'd0);

    // Time wrap with a start pulse ignored during RUN
    do_reset();
    start = 1'b1; n_samples = 16'd3; t_step = 16'h8000;
    tick();
    n_samples = 16'd10; t_step = 16'd1;
    tick();
    start = 1'b0;
    check("wrap t1 (start ignored)", 64'(t_out), 64'h8000);
    check("wrap busy",               64'(busy),  64'd1);
    tick();
    check("wrap t2", 64'(t_out), 64'h0000);
    tick();
    check("wrap done",  64'(done),  64'd1);
    check("wrap level", 64'(level), 64'd3);
    tick();
    check("wrap level hold", 64'(level), 64'd3);
    rd_req = 1'b1;
    tick();
    check("wrap read0", 64'(rd_data), 64'h0000);
    tick();
    check("wrap read1", 64'(rd_data), 64'h8000);
    tick();
    check("wrap read2", 64'(rd_data), 64'h0000);
    rd_req = 1'b0;

    // Asynchronous reset mid-burst, then a fresh burst
    do_reset();
    start = 1'b1; n_samples = 16'd8; t_step = 16'd1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    check("abort pre level", 64'(level), 64'd5);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("async reset");
    @(posedge ti_clk);
    #1;
    rst_n = 1'b1;
    tick();
    check("post reset idle busy", 64'(busy), 64'd0);
    start = 1'b1; n_samples = 16'd2; t_step = 16'd7;
    tick();
    start = 1'b0;
    repeat (2) tick();
    check("new burst done",  64'(done),  64'd1);
    check("new burst level", 64'(level), 64'd2);
    rd_req = 1'b1;
    tick();
    check("new read0", 64'(rd_data), 64'd0);
    tick();
    check("new read1", 64'(rd_data), 64'd7);
    tick();
    rd_req = 1'b0;
    check("new read empty valid", 64'(rd_valid),  64'd0);
    check("new read empty uflow", 64'(underflow), 64'd1);
    check("new read empty data",  64'(rd_data),   64'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wave_sample_streamer.md
WAVE_SAMPLE_STREAMER -- requirements
Module: wave_sample_streamer

Interface
REQ-001 Parameter DEPTH, default 16, FIFO depth in samples (power of two, 4..256).
REQ-002 Parameter W, default 16, sample width (upper W bits of the compute result).
REQ-003 ti_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 start  input  1  single-cycle trigger to begin a sample burst.
REQ-006 n_samples  input  16  burst length; sampled on an accepted start.
REQ-007 t_step  input  16  time increment per sample; sampled on an accepted start.
REQ-008 t_out  output  16  time argument driven to the external combinational waveform compute.
REQ-009 result_in  input  32  compute result for the current t_out, valid in the same cycle.
REQ-010 rd_req  input  1  host read strobe; one sample per asserted cycle.
REQ-011 rd_data  output  W  sample popped by the last accepted rd_req.
REQ-012 rd_valid  output  1  one-cycle pulse marking rd_data as new.
REQ-013 busy  output  1  high in RUN.
REQ-014 done  output  1  high in DONE.
REQ-015 level  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-016 underflow  output  1  sticky flag, set when rd_req arrives while the FIFO is empty.

Function
REQ-017 Three states: IDLE, RUN, DONE; encoding is free.
REQ-018 IDLE or DONE + start: capture n_samples into remaining and t_step into step; t_out <= 0; go to RUN. If n_samples == 0, go to DONE instead.
REQ-019 RUN + start: ignore start; no state change.
REQ-020 RUN, FIFO not full: write result_in[31:32-W]; t_out <= t_out + step (mod 2^16, wraps silently); remaining <= remaining - 1.
REQ-021 RUN, write with remaining == 1: go to DONE in the same edge; exactly n_samples writes per burst.
REQ-022 RUN, FIFO full at the start of the cycle: stall. No write; t_out and remaining hold. Fullness is judged before any same-cycle read.
REQ-023 DONE holds until the next start; FIFO contents are never cleared by start.
REQ-024 Read, rd_req with FIFO non-empty: pop the oldest entry; rd_data registered on that edge; rd_valid = 1 for the following cycle only.
REQ-025 Read, rd_req with FIFO empty: no pop; rd_data holds; rd_valid stays 0; underflow <= 1.
REQ-026 Simultaneous write and read in one cycle: both occur; level is unchanged.
REQ-027 level = writes - reads since reset; never exceeds DEPTH, never goes below 0.
REQ-028 Read pointer and write pointer wrap modulo DEPTH.
REQ-029 Read latency: rd_req at edge k gives rd_data/rd_valid valid after edge k.
REQ-030 Write-to-readable latency: a sample written at edge k can be popped by rd_req sampled at edge k+1.

Reset
REQ-031 While rst_n == 0, regardless of clock: state = IDLE; t_out = 0; remaining = 0; step = 0; pointers = 0; level = 0; rd_data = 0; rd_valid = 0; busy = 0; done = 0; underflow = 0.
REQ-032 Reset asserted mid-burst aborts the burst and empties the FIFO; after release the block is in IDLE and waits for start.
REQ-033 underflow clears only on reset.

Verification
REQ-034 start, n_samples=4, t_step=3, result_in = {t_out,16'h0}: FIFO receives 0,3,6,9; done after 4 RUN cycles; reads return 0,3,6,9 in order.
REQ-035 n_samples=20, DEPTH=16, no reads: 16 writes, then stall with busy=1, level=16, t_out=48 (t_step=3); one read resumes writing; after 4 further reads (one per cycle), done=1.
REQ-036 rd_req on empty FIFO after reset: rd_valid stays 0, underflow=1; it stays 1 after a later successful read.
REQ-037 start with n_samples=0: done=1 on the next cycle, no writes, level=0.
REQ-038 t_step=16'h8000, n_samples=3: t_out sequence 0, 8000, 0 (wrap); start pulsed during RUN is ignored.
REQ-039 Assert rst_n=0 mid-burst with level=5: all outputs go to reset values at once; after release, start a new burst and check that reads return only new samples.
